// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch display path: digit count,
// active-low segment glyphs ({g,f,e,d,c,b,a}) and the decimal point position.
package stopwatch_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DP_DIGIT   = 2;

    typedef logic [3:0]                    bcd_t;
    typedef logic [6:0]                    seg_t;
    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;
    typedef bcd_t [NUM_DIGITS-1:0]         snap_t;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low one-hot anode pattern selecting digit idx
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_idx_t idx);
        anode_sel = ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low 7-segment glyph. Codes 10..15 are not BCD and are
// shown as a dash so a corrupted counter is visible rather than misleading.
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Glyph lookup
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display
// showing a stopwatch as ss.hh. Each digit owns SCAN_DIV clocks; the four
// input digits are snapshotted together at the end of digit 3's slot so a
// frame never mixes old and new values. an/seg/dp are registered and trail
// the digit index by one clock.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN: blank digit 3 when its
// snapshot value is zero (its anode is still driven).
module seg7_scan
    import stopwatch_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
    localparam digit_idx_t LastIdx = digit_idx_t'(NUM_DIGITS - 1);
    localparam digit_idx_t DpIdx   = digit_idx_t'(DP_DIGIT);

    logic [CntW-1:0] cnt_q, cnt_d;
    digit_idx_t      idx_q, idx_d;
    snap_t           snap_q, snap_d;
    logic [3:0]      an_q, an_d;
    seg_t            seg_q, seg_d;
    logic            dp_q, dp_d;

    logic            slot_end;
    bcd_t            cur_digit;
    seg_t            dec_seg;

    assign slot_end  = (cnt_q == CntMax);
    assign cur_digit = snap_q[idx_q];

    // Scan counter, digit index and frame snapshot next-state
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            // Capture all digits at once on the frame boundary
            if (idx_q == LastIdx) begin
                snap_d = {d3, d2, d1, d0};
            end
        end
    end

    // Scan state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
        end
    end

    bcd_to_7seg u_bcd_to_7seg (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    // Output next-state from the current index and snapshot
    always_comb begin
        an_d  = anode_sel(idx_q);
        seg_d = dec_seg;
        dp_d  = (idx_q != DpIdx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if ((idx_q == LastIdx) && (cur_digit == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
`endif
    end

    // Registered display outputs; all dark during reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with SCAN_DIV=4. Expected {an,seg,dp}
// per cycle are queued a frame ahead when the digits are driven, and popped
// on every falling edge.
module tb_seg7_scan;

    localparam int unsigned Div = 4;
    localparam int unsigned FrameCycles = 4 * Div;

    localparam logic [6:0] G0 = 7'h40;
    localparam logic [6:0] G1 = 7'h79;
    localparam logic [6:0] G2 = 7'h24;
    localparam logic [6:0] G3 = 7'h30;
    localparam logic [6:0] G4 = 7'h19;
    localparam logic [6:0] G5 = 7'h12;
    localparam logic [6:0] G6 = 7'h02;
    localparam logic [6:0] G7 = 7'h78;
    localparam logic [6:0] G8 = 7'h00;
    localparam logic [6:0] G9 = 7'h10;
    localparam logic [6:0] GDash  = 7'h3F;
    localparam logic [6:0] GBlank = 7'h7F;
    localparam logic [11:0] RstOut = {4'b1111, 7'b1111111, 1'b1};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg7_scan #(
        .SCAN_DIV (Div)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d3, d2, d1, d0;
        logic [6:0] e0, e1, e2, e3;
    } vec_t;

    vec_t        vecs[5];
    logic [11:0] sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          pops  = 0;

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // Queue one full frame of expected outputs for the given snapshot glyphs
    task automatic push_frame(input logic [3:0] d3v, input logic [6:0] e0,
                              input logic [6:0] e1, input logic [6:0] e2,
                              input logic [6:0] e3);
        logic [6:0] e[4];
        logic [3:0] a;
        logic       p;
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        e[3] = e3;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d3v == 4'd0) e[3] = GBlank;
`else
        if (d3v == 4'd0) e[3] = G0;
`endif
        for (int i = 0; i < 4; i++) begin
            a = ~(4'b0001 << i);
            p = (i == 2) ? 1'b0 : 1'b1;
            for (int c = 0; c < int'(Div); c++) sb_q.push_back({a, e[i], p});
        end
    endtask

    task automatic cycle();
        logic [11:0] exp;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check($sformatf("scan[%0d]", pops), {an, seg, dp}, exp);
            pops++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drive(input vec_t v);
        d3 = v.d3;
        d2 = v.d2;
        d1 = v.d1;
        d0 = v.d0;
        push_frame(v.d3, v.e0, v.e1, v.e2, v.e3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tear;
        vecs[0] = '{4'd5, 4'd9, 4'd2, 4'd7, G7, G2, G9, G5};
        vecs[1] = '{4'd0, 4'd4, 4'hC, 4'd1, G1, GDash, G4, G0};
        vecs[2] = '{4'd8, 4'd6, 4'd3, 4'd0, G0, G3, G6, G8};
        vecs[3] = '{4'hF, 4'hA, 4'hB, 4'hD, GDash, GDash, GDash, GDash};
        vecs[4] = '{4'd1, 4'd0, 4'd9, 4'd8, G8, G9, G0, G1};
        tear    = '{4'd0, 4'd0, 4'd0, 4'd3, G3, G0, G0, G0};

        reset = 1'b1;
        d0 = 4'd0;
        d1 = 4'd0;
        d2 = 4'd0;
        d3 = 4'd0;
        #1 check("reset_async", {an, seg, dp}, RstOut);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", {an, seg, dp}, RstOut);
        end

        // First frame after reset shows the zero snapshot
        reset = 1'b0;
        push_frame(4'd0, G0, G0, G0, G0);
        foreach (vecs[i]) begin
            drive(vecs[i]);
            run(FrameCycles);
        end

        // Tearing: d0 changes while index 1 of the frame showing 3
        drive(tear);
        run(FrameCycles);
        run(Div);
        d0 = 4'd8;
        push_frame(4'd0, G8, G0, G0, G0);
        run(FrameCycles - Div);
        run(FrameCycles);

        // Reset with index 2 and scan counter 2
        run(10);
        check("pre_reset_slot", {an, seg, dp}, {4'b1011, G0, 1'b0});
        reset = 1'b1;
        #1 check("reset_mid_async", {an, seg, dp}, RstOut);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_mid_hold", {an, seg, dp}, RstOut);
        end
        reset = 1'b0;
        push_frame(4'd0, G0, G0, G0, G0);
        run(FrameCycles);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20.
REQ-002 The block SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have ports d0, d1, d2, d3  input  4 each  BCD digits from the stopwatch counter. d0 is hundredths, d1 is tenths, d2 is seconds units, d3 is seconds tens.
REQ-005 The block SHALL have port an  output  4  digit anode enables, active-low; an[i] selects display digit i.
REQ-006 The block SHALL have port seg  output  7  segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
REQ-007 The block SHALL have port dp  output  1  decimal point cathode, active-low.

Function
REQ-008 A scan counter SHALL count 0..SCAN_DIV-1 and wrap to 0; the cycle in which it equals SCAN_DIV-1 is the "slot end".
REQ-009 A 2-bit digit index SHALL advance 0->1->2->3->0 on each slot end, one step per slot end.
REQ-010 On a slot end while the index is 3, a snapshot register SHALL capture d0..d3 together, so that a frame never mixes old and new digits.
REQ-011 The next frame (index 0..3) SHALL display only snapshot values; input changes mid-frame SHALL NOT be visible until the following frame.
REQ-012 The outputs an, seg and dp SHALL be registered and SHALL reflect the index and snapshot one clock after the index changes.
REQ-013 During each slot, exactly one an bit SHALL be low, namely an[index].
REQ-014 seg SHALL decode the active snapshot digit: 0..9 as standard 7-segment glyphs; 10..15 as a dash (only g lit, seg=7'b0111111).
REQ-015 dp SHALL be low only while index==2 (display reads ss.hh); otherwise dp SHALL be high.
REQ-016 The 0..SCAN_DIV-1 scan counter SHALL be sized $clog2(SCAN_DIV) bits with no overflow beyond wrap.

Reset
REQ-017 While reset is high, the block SHALL hold an=4'b1111, seg=7'b1111111, dp=1, scan counter=0, index=0 and snapshot=0, independent of clk.
REQ-018 After reset deasserts, the first visible slot SHALL show index 0 with snapshot 0, i.e. glyph "0", starting on the first clock edge.
REQ-019 A reset asserted mid-slot or mid-frame SHALL discard partial scan state; no partial frame SHALL resume.

Configuration
REQ-020 When macro SEG7_LEADING_ZERO_BLANK_EN is defined, the block SHALL blank digit 3 (seg=7'b1111111, an[3] still low) whenever snapshot d3==0.
REQ-021 When SEG7_LEADING_ZERO_BLANK_EN is not defined, digit 3 SHALL display its value normally, including "0"; digits 0..2 SHALL never be blanked in either build.

Structure
REQ-022 Package stopwatch_pkg SHALL hold NUM_DIGITS=4, the segment glyph constants SEG_0..SEG_9, SEG_DASH and SEG_BLANK, and the dp digit position DP_DIGIT=2.
REQ-023 The BCD-to-segment decode SHALL be a sub-module bcd_to_7seg (4-bit in, 7-bit active-low out), instantiated once on the muxed snapshot digit.

Verification
REQ-024 Reset check: run with SCAN_DIV=4, hold reset 3 cycles -> an=1111, seg=1111111, dp=1 throughout; after release, an=1110 with seg=SEG_0.
REQ-025 Scan order: run with SCAN_DIV=4 -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles and repeating, and dp=0 only while an=1011.
REQ-026 Decode: apply d3..d0=5,9,2,7 before a frame boundary -> next frame shows SEG_7, SEG_2 with dp, SEG_9, SEG_5 on digits 0..3.
REQ-027 Tearing: change d0 from 3 to 8 while index=1 -> current frame keeps SEG_3 on digit 0; the following frame shows SEG_8.
REQ-028 Invalid BCD and blanking: apply d1=4'hC and d3=0 -> digit 1 shows SEG_DASH; digit 3 is blank with the macro defined and shows SEG_0 without it.
REQ-029 Reset mid-scan: assert reset while index=2 and the scan counter=2 -> outputs return immediately to reset values; after release the scan restarts at digit 0 with a full 4-cycle slot.
